// File: rtl/lfsr_xnor.sv
// Fibonacci LFSR with XNOR feedback, seed loading and a seed-match flag.
// Taps follow the XAPP052 maximal-length table; unsupported widths abort elaboration.
module lfsr_xnor #(
   parameter int NUM_BITS = 128
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   input  logic                i_Enable,
   input  logic                i_Seed_DV,
   input  logic [NUM_BITS-1:0] i_Seed_Data,
   output logic [NUM_BITS-1:0] o_LFSR_Data,
   output logic                o_LFSR_Done
);

   // Up to four 1-indexed tap positions per width, packed MSB first; 0 = unused slot.
   function automatic logic [31:0] tap_list(input int n);
      logic [31:0] t;
      case (n)
         3:       t = {8'd3,   8'd2,   8'd0,   8'd0};
         4:       t = {8'd4,   8'd3,   8'd0,   8'd0};
         5:       t = {8'd5,   8'd3,   8'd0,   8'd0};
         6:       t = {8'd6,   8'd5,   8'd0,   8'd0};
         7:       t = {8'd7,   8'd6,   8'd0,   8'd0};
         8:       t = {8'd8,   8'd6,   8'd5,   8'd4};
         9:       t = {8'd9,   8'd5,   8'd0,   8'd0};
         10:      t = {8'd10,  8'd7,   8'd0,   8'd0};
         11:      t = {8'd11,  8'd9,   8'd0,   8'd0};
         12:      t = {8'd12,  8'd6,   8'd4,   8'd1};
         13:      t = {8'd13,  8'd4,   8'd3,   8'd1};
         14:      t = {8'd14,  8'd5,   8'd3,   8'd1};
         15:      t = {8'd15,  8'd14,  8'd0,   8'd0};
         16:      t = {8'd16,  8'd15,  8'd13,  8'd4};
         17:      t = {8'd17,  8'd14,  8'd0,   8'd0};
         18:      t = {8'd18,  8'd11,  8'd0,   8'd0};
         19:      t = {8'd19,  8'd6,   8'd2,   8'd1};
         20:      t = {8'd20,  8'd17,  8'd0,   8'd0};
         21:      t = {8'd21,  8'd19,  8'd0,   8'd0};
         22:      t = {8'd22,  8'd21,  8'd0,   8'd0};
         23:      t = {8'd23,  8'd18,  8'd0,   8'd0};
         24:      t = {8'd24,  8'd23,  8'd22,  8'd17};
         25:      t = {8'd25,  8'd22,  8'd0,   8'd0};
         26:      t = {8'd26,  8'd6,   8'd2,   8'd1};
         27:      t = {8'd27,  8'd5,   8'd2,   8'd1};
         28:      t = {8'd28,  8'd25,  8'd0,   8'd0};
         29:      t = {8'd29,  8'd27,  8'd0,   8'd0};
         30:      t = {8'd30,  8'd6,   8'd4,   8'd1};
         31:      t = {8'd31,  8'd28,  8'd0,   8'd0};
         32:      t = {8'd32,  8'd22,  8'd2,   8'd1};
         64:      t = {8'd64,  8'd63,  8'd61,  8'd60};
         128:     t = {8'd128, 8'd126, 8'd101, 8'd99};
         default: t = 32'd0;
      endcase
      return t;
   endfunction

   function automatic logic [127:0] tap_mask(input int n);
      logic [127:0] m;
      logic [31:0]  t;
      int           idx;
      m = '0;
      t = tap_list(n);
      for (int k = 0; k < 4; k++) begin
         idx = int'(t[8*k +: 8]);
         if (idx != 0) m[7'(idx - 1)] = 1'b1;
      end
      return m;
   endfunction

   localparam logic [127:0]          TAP_FULL = tap_mask(NUM_BITS);
   localparam logic [NUM_BITS-1:0]   TAPS     = TAP_FULL[NUM_BITS-1:0];

   if (TAP_FULL == 128'd0) begin : g_bad_width
      $error("lfsr_xnor: unsupported NUM_BITS %0d", NUM_BITS);
   end

   logic [NUM_BITS-1:0] r;
   logic                fb;

   // Even-count XNOR chains reduce to an inverted parity of the tapped bits.
   assign fb = ~^(r & TAPS);

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r <= '0;
      end else if (i_Enable) begin
         if (i_Seed_DV) r <= i_Seed_Data;
         else           r <= {r[NUM_BITS-2:0], fb};
      end
   end

   assign o_LFSR_Data = r;
   assign o_LFSR_Done = (r == i_Seed_Data);

endmodule

// File: tb/tb_lfsr_xnor.sv
// Bench for lfsr_xnor: 128-bit reference instance plus 4-bit and 8-bit instances
// for period and lock-up behaviour, with a queue-based scoreboard.
module tb_lfsr_xnor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b0;

   logic         en_a = 1'b0, sdv_a = 1'b0, done_a;
   logic [127:0] seed_a = '0, data_a;
   logic         en_b = 1'b0, sdv_b = 1'b0, done_b;
   logic [3:0]   seed_b = '0, data_b;
   logic         en_c = 1'b0, sdv_c = 1'b0, done_c;
   logic [7:0]   seed_c = '0, data_c;

   lfsr_xnor #(.NUM_BITS(128)) u_a (
      .i_Clk(clk), .i_Rst(rst), .i_Enable(en_a), .i_Seed_DV(sdv_a),
      .i_Seed_Data(seed_a), .o_LFSR_Data(data_a), .o_LFSR_Done(done_a));
   lfsr_xnor #(.NUM_BITS(4)) u_b (
      .i_Clk(clk), .i_Rst(rst), .i_Enable(en_b), .i_Seed_DV(sdv_b),
      .i_Seed_Data(seed_b), .o_LFSR_Data(data_b), .o_LFSR_Done(done_b));
   lfsr_xnor #(.NUM_BITS(8)) u_c (
      .i_Clk(clk), .i_Rst(rst), .i_Enable(en_c), .i_Seed_DV(sdv_c),
      .i_Seed_Data(seed_c), .o_LFSR_Data(data_c), .o_LFSR_Done(done_c));

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [127:0] exp_q[$];
   logic [127:0] m_a = '0;
   logic [3:0]   m_b = '0;
   logic [7:0]   m_c = '0;

   localparam logic [127:0] DEAD  = {4{32'hDEADBEEF}};
   localparam logic [127:0] SHIFT = {4{32'hBD5B7DDF}};
   localparam logic [127:0] CAFE  = {4{32'hCAFEFEED}};

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference next-state models, written out from the tap table per width.
   function automatic logic [127:0] nxt_a(input logic [127:0] r, input logic en,
                                          input logic sdv, input logic [127:0] s);
      if (!en)     return r;
      else if (sdv) return s;
      else          return {r[126:0], ~(r[127] ^ r[125] ^ r[100] ^ r[98])};
   endfunction

   function automatic logic [3:0] nxt_b(input logic [3:0] r, input logic en,
                                        input logic sdv, input logic [3:0] s);
      if (!en)     return r;
      else if (sdv) return s;
      else          return {r[2:0], ~(r[3] ^ r[2])};
   endfunction

   function automatic logic [7:0] nxt_c(input logic [7:0] r, input logic en,
                                        input logic sdv, input logic [7:0] s);
      if (!en)     return r;
      else if (sdv) return s;
      else          return {r[6:0], ~(r[7] ^ r[5] ^ r[4] ^ r[3])};
   endfunction

   task automatic step_a(input string tag);
      m_a = nxt_a(m_a, en_a, sdv_a, seed_a);
      exp_q.push_back(m_a);
      @(posedge clk); #1;
      check(tag, data_a, exp_q.pop_front());
   endtask

   task automatic step_b(input string tag);
      m_b = nxt_b(m_b, en_b, sdv_b, seed_b);
      exp_q.push_back({124'd0, m_b});
      @(posedge clk); #1;
      check(tag, {124'd0, data_b}, exp_q.pop_front());
   endtask

   task automatic step_c(input string tag);
      m_c = nxt_c(m_c, en_c, sdv_c, seed_c);
      exp_q.push_back({120'd0, m_c});
      @(posedge clk); #1;
      check(tag, {120'd0, data_c}, exp_q.pop_front());
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      m_a = '0; m_b = '0; m_c = '0;
      check("rst_data_a", data_a, 128'd0);
      check("rst_data_b", {124'd0, data_b}, 128'd0);
      check("rst_done_a", {127'd0, done_a}, {127'd0, seed_a == 128'd0});
      #1 rst = 1'b0;
   endtask

   initial begin
      int seen[16];
      int pulses;

      // Clock/reset: leave the registers unreset for one edge, then reset between edges.
      @(posedge clk); #1;
      async_reset();
      check("rst_done_seed0", {127'd0, done_a}, 128'd1);
      seed_a = DEAD;
      #1;
      check("rst_done_seeddead", {127'd0, done_a}, 128'd0);

      step_a("idle_after_rst");

      // Seed load is gated by the enable.
      en_a = 1'b0; sdv_a = 1'b1;
      for (int i = 0; i < 3; i++) step_a("seed_gated");
      en_a = 1'b1;
      step_a("seed_load");
      check("seed_load_const", data_a, DEAD);
      check("seed_load_done", {127'd0, done_a}, 128'd1);

      sdv_a = 1'b0;
      step_a("first_shift");
      check("first_shift_const", data_a, SHIFT);
      check("first_shift_done", {127'd0, done_a}, 128'd0);

      for (int i = 0; i < 40; i++) begin
         en_a  = ($urandom_range(0, 3) != 0);
         sdv_a = ($urandom_range(0, 9) == 0);
         step_a("random_run");
         check("random_done", {127'd0, done_a}, {127'd0, m_a == seed_a});
      end

      en_a = 1'b0; sdv_a = 1'b0;
      for (int i = 0; i < 10; i++) step_a("hold");

      // Reset in the middle of a sequence, then shift out of the all-zeros state.
      en_a = 1'b1;
      step_a("pre_mid_rst");
      async_reset();
      en_a = 1'b0;
      step_a("post_rst_hold");
      en_a = 1'b1;
      step_a("shift_from_zero");
      check("shift_from_zero_const", data_a, 128'd1);

      // All-ones lock-up at 128 bits.
      seed_a = '1; sdv_a = 1'b1;
      step_a("load_ones_a");
      sdv_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step_a("lockup_a");
         check("lockup_a_done", {127'd0, done_a}, 128'd1);
      end

      // No return to the seed over a long run from CAFEFEED.
      seed_a = CAFE; sdv_a = 1'b1;
      step_a("load_cafe");
      sdv_a = 1'b0;
      pulses = 0;
      for (int i = 0; i < 3000; i++) begin
         step_a("cafe_run");
         if (done_a) pulses++;
      end
      check("cafe_no_repeat", 128'(pulses), 128'd0);
      en_a = 1'b0;

      // 4-bit period: done every 15 edges, each non-1111 value once per period.
      for (int v = 0; v < 16; v++) seen[v] = 0;
      en_b = 1'b1; sdv_b = 1'b1; seed_b = 4'b0001;
      step_b("load_b");
      check("load_b_done", {127'd0, done_b}, 128'd1);
      sdv_b = 1'b0;
      pulses = 0;
      for (int i = 1; i <= 30; i++) begin
         step_b("period_b");
         if (i <= 15) seen[data_b]++;
         if (done_b) pulses++;
         check("period_b_done", {127'd0, done_b}, {127'd0, (i % 15) == 0});
      end
      check("period_b_pulses", 128'(pulses), 128'd2);
      for (int v = 0; v < 15; v++) check("period_b_seen", 128'(seen[v]), 128'd1);
      check("period_b_no_ones", 128'(seen[15]), 128'd0);
      en_b = 1'b0;

      // 8-bit lock-up.
      en_c = 1'b1; sdv_c = 1'b1; seed_c = 8'hFF;
      step_c("load_c");
      sdv_c = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step_c("lockup_c");
         check("lockup_c_done", {127'd0, done_c}, 128'd1);
      end
      check("lockup_c_const", {120'd0, data_c}, 128'hFF);

      check("queue_drained", 128'(exp_q.size()), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
